// File: rtl/datamem_port_arbiter.sv
// Shares the single-port AES data memory between the CPU load/store port and the host loader.
// The CPU wins by default; a pending host access is forced through after MAX_WAIT busy cycles.
module datamem_port_arbiter #(
    parameter int DEPTH    = 70,
    parameter int AW       = 7,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic        host_ready,
    output logic        host_ack,
    output logic        host_err,
    output logic [31:0] host_rdata,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_datain,
    input  logic [31:0] mem_dataout
);

    typedef enum logic [1:0] {IDLE, PEND, GRANT, ACK} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        out_of_range;

    // Any address bit above the word-index field also counts as out of range.
    assign out_of_range = (|host_addr[31:AW+2]) || ({1'b0, host_addr[AW+1:2]} >= DEPTH_L);

    always_ff @(posedge clk) begin
        if (state == IDLE && host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= IDLE;
            wait_cnt   <= 8'd0;
            host_ready <= 1'b1;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_req) begin
                        wait_cnt   <= 8'd0;
                        host_ready <= 1'b0;
                        if (out_of_range) begin
                            state    <= ACK;
                            host_ack <= 1'b1;
                            host_err <= 1'b1;
                        end else begin
                            state <= PEND;
                        end
                    end
                end
                PEND: begin
                    if (!cpu_en || wait_cnt == WAIT_LAST) begin
                        state <= GRANT;
                    end else if (wait_cnt != 8'hff) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GRANT: begin
                    // For a write this captures the word as it was before the write lands.
                    host_rdata <= mem_dataout;
                    host_ack   <= 1'b1;
                    host_err   <= 1'b0;
                    state      <= ACK;
                end
                ACK: begin
                    host_ack   <= 1'b0;
                    host_err   <= 1'b0;
                    host_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    host_ready <= 1'b1;
                    host_ack   <= 1'b0;
                    host_err   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr   = cpu_addr;
        mem_datain = cpu_wdata;
        mem_we     = cpu_en ? cpu_we : 4'b0000;
        cpu_stall  = 1'b0;
        if (state == GRANT) begin
            mem_addr   = lat_addr;
            mem_datain = lat_wdata;
            mem_we     = {4{lat_we}};
            cpu_stall  = cpu_en;
        end
    end

    assign cpu_rdata = mem_dataout;

endmodule

// File: tb/tb_datamem_port_arbiter.sv
// Bench for datamem_port_arbiter: directed scenarios plus random traffic against a
// timestamp-based transaction model and a reference copy of the memory.
module tb_datamem_port_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        cpu_en = 1'b0;
    logic [3:0]  cpu_we = 4'b0;
    logic [31:0] cpu_addr = 32'd0;
    logic [31:0] cpu_wdata = 32'd0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [31:0] host_addr = 32'd0;
    logic [31:0] host_wdata = 32'd0;
    logic        host_ready;
    logic        host_ack;
    logic        host_err;
    logic [31:0] host_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    datamem_port_arbiter #(.DEPTH(70), .AW(7), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .clrn(clrn),
        .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 18) return 32'h2a2388a0;
        return (32'h9e3779b9 * 32'(i + 1)) ^ 32'h0f0f0f0f;
    endfunction

    // Memory seen by the DUT: combinational read, byte-lane synchronous write.
    logic [31:0] mem [0:127];
    logic loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_datain[8*b +: 8];
        end
    end
    assign mem_dataout = mem[mem_addr[8:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory image plus host-transaction timestamps.
    logic [31:0] ref_mem [0:127];
    int          cyc = 0;
    bit          live = 1'b0;
    int          acc_c, grant_c, ack_c;
    bit          r_we, r_err;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] exp_rdata = 32'd0;

    initial begin : compare
        bit in_grant, in_ack, e_ready;
        logic [31:0] e_addr;
        logic [3:0]  e_we;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (chk_on) begin
                if (!clrn) begin
                    live = 1'b0;
                    exp_rdata = 32'd0;
                    e_we = cpu_en ? cpu_we : 4'b0;
                    chk("rst_ready", 32'(host_ready), 32'd1);
                    chk("rst_ack", 32'(host_ack), 32'd0);
                    chk("rst_err", 32'(host_err), 32'd0);
                    chk("rst_stall", 32'(cpu_stall), 32'd0);
                    chk("rst_rdata", host_rdata, 32'd0);
                    chk("rst_mem_we", 32'(mem_we), 32'(e_we));
                    chk("rst_mem_addr", mem_addr, cpu_addr);
                    for (int b = 0; b < 4; b++)
                        if (e_we[b]) ref_mem[cpu_addr[8:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
                end else begin
                    in_grant = live && (cyc == grant_c);
                    in_ack   = live && (cyc == ack_c);
                    e_ready  = !live;
                    e_addr   = in_grant ? r_addr : cpu_addr;
                    e_we     = in_grant ? (r_we ? 4'hf : 4'h0) : (cpu_en ? cpu_we : 4'h0);
                    chk("host_ready", 32'(host_ready), 32'(e_ready));
                    chk("host_ack", 32'(host_ack), 32'(in_ack));
                    chk("cpu_stall", 32'(cpu_stall), 32'(in_grant && cpu_en));
                    chk("mem_we", 32'(mem_we), 32'(e_we));
                    if (in_grant) chk("mem_addr_host", {mem_addr[31:2], 2'b00}, {e_addr[31:2], 2'b00});
                    else          chk("mem_addr_cpu", mem_addr, e_addr);
                    if (in_grant && r_we) chk("mem_datain_host", mem_datain, r_wdata);
                    if (!in_grant) chk("mem_datain_cpu", mem_datain, cpu_wdata);
                    chk("cpu_rdata", cpu_rdata, ref_mem[e_addr[8:2]]);
                    if (in_ack) chk("host_err", 32'(host_err), 32'(r_err));
                    if (in_ack && !r_err) chk("host_rdata", host_rdata, exp_rdata);
                    // Effects of the coming edge.
                    if (in_grant) begin
                        exp_rdata = ref_mem[r_addr[8:2]];
                        if (r_we) ref_mem[r_addr[8:2]] = r_wdata;
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (e_we[b]) ref_mem[cpu_addr[8:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
                    end
                    if (in_ack) live = 1'b0;
                    if (e_ready && host_req) begin
                        live = 1'b1;  acc_c = cyc;
                        r_we = host_we;  r_addr = host_addr;  r_wdata = host_wdata;
                        r_err = (host_addr[31:2] >= 30'd70);
                        grant_c = -10;
                        ack_c = r_err ? cyc + 1 : -10;
                    end else if (live && !r_err && grant_c < 0 && cyc > acc_c &&
                                 (!cpu_en || cyc - acc_c == MAX_WAIT)) begin
                        grant_c = cyc + 1;
                        ack_c   = cyc + 2;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held_val = 32'd0;

    task automatic cpu_drive(input bit busy, input bit held);
        if (!busy) begin
            cpu_en = 1'b0;
            cpu_we = 4'b0;
        end else if (!held) begin
            cpu_en    = 1'b1;
            cpu_we    = 4'hf;
            cpu_addr  = 32'hc0;
            cpu_wdata = cpu_wdata + 32'd1;
        end
    endtask

    // Issues one host request from an IDLE cycle; returns in the ack cycle (or after a bound).
    task automatic host_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input bit busy, output int lat, output int stalls,
                            output int stall_at, output int we_seen);
        bit held = 1'b0;
        host_req = 1'b1;  host_we = we;  host_addr = addr;  host_wdata = wd;
        cpu_drive(busy, 1'b0);
        tick();
        host_req = 1'b0;
        lat = -1;  stalls = 0;  stall_at = -1;  we_seen = 0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            cpu_drive(busy, held);
            #1;
            if (cpu_stall) begin
                stalls++;  stall_at = n;  held_val = cpu_wdata;  held = 1'b1;
            end else begin
                held = 1'b0;
            end
            if (!busy && mem_we != 4'b0) we_seen++;
            if (host_ack) lat = n;
            else tick();
        end
    endtask

    initial begin : stim
        int lat, stalls, stall_at, we_seen, acks, ack1, ack2, bad_words;
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        chk_on = 1'b1;
        chk("reset_ready", 32'(host_ready), 32'd1);
        chk("reset_ack", 32'(host_ack), 32'd0);
        chk("reset_err", 32'(host_err), 32'd0);
        chk("reset_rdata", host_rdata, 32'd0);
        chk("reset_stall", 32'(cpu_stall), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        tick();

        // Idle CPU, host write.
        host_txn(1'b1, 32'h28, 32'h53495459, 1'b0, lat, stalls, stall_at, we_seen);
        chk("wr_latency", 32'(lat), 32'd3);
        chk("wr_err", 32'(host_err), 32'd0);
        chk("wr_stalls", 32'(stalls), 32'd0);
        tick();
        chk("wr_mem_0a", mem[10], 32'h53495459);

        // CPU busy every cycle, host read forced through after MAX_WAIT.
        host_txn(1'b0, 32'h48, 32'd0, 1'b1, lat, stalls, stall_at, we_seen);
        chk("busy_latency", 32'(lat), 32'd10);
        chk("busy_stall_count", 32'(stalls), 32'd1);
        chk("busy_stall_cycle", 32'(stall_at), 32'd9);
        chk("busy_rdata", host_rdata, 32'h2a2388a0);
        tick();
        chk("busy_held_write", mem[48], held_val);
        cpu_en = 1'b0;

        // Out-of-range host write.
        host_txn(1'b1, 32'h118, 32'h12345678, 1'b0, lat, stalls, stall_at, we_seen);
        chk("oor_latency", 32'(lat), 32'd1);
        chk("oor_err", 32'(host_err), 32'd1);
        chk("oor_mem_we_seen", 32'(we_seen), 32'd0);
        tick();
        chk("oor_mem_70", mem[70], init_word(70));

        // CPU byte write with host idle.
        cpu_en = 1'b1;  cpu_we = 4'b0001;  cpu_addr = 32'h38;  cpu_wdata = 32'haabbccdd;
        #1;
        chk("byte_mem_we", 32'(mem_we), 32'd1);
        chk("byte_stall", 32'(cpu_stall), 32'd0);
        tick();
        cpu_en = 1'b0;  cpu_we = 4'b0;
        chk("byte_mem_0e", mem[14], (init_word(14) & 32'hffffff00) | 32'h000000dd);

        // Reset pulse while the host write is pending.
        cpu_en = 1'b1;  cpu_we = 4'b0;  cpu_addr = 32'h40;
        host_req = 1'b1;  host_we = 1'b1;  host_addr = 32'h14;  host_wdata = 32'hdeadbeef;
        tick();
        host_req = 1'b0;
        tick();
        clrn = 1'b0;
        #1;
        chk("pulse_ready", 32'(host_ready), 32'd1);
        chk("pulse_ack", 32'(host_ack), 32'd0);
        chk("pulse_stall", 32'(cpu_stall), 32'd0);
        chk("pulse_rdata", host_rdata, 32'd0);
        tick();
        clrn = 1'b1;  cpu_en = 1'b0;
        repeat (4) tick();
        chk("pulse_no_write", mem[5], init_word(5));
        host_txn(1'b0, 32'h14, 32'd0, 1'b0, lat, stalls, stall_at, we_seen);
        chk("pulse_after_latency", 32'(lat), 32'd3);
        chk("pulse_after_rdata", host_rdata, init_word(5));
        tick();

        // Back-to-back requests with host_req held high.
        host_req = 1'b1;  host_we = 1'b1;  host_addr = 32'h1c;  host_wdata = 32'h0badf00d;
        tick();
        acks = 0;  ack1 = -1;  ack2 = -1;
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) host_req = 1'b0;
            #1;
            if (host_ack) begin
                acks++;
                if (ack1 < 0) ack1 = n; else ack2 = n;
            end
            if (n == 4) chk("b2b_ready_after_ack", 32'(host_ready), 32'd1);
            tick();
        end
        chk("b2b_ack_count", 32'(acks), 32'd2);
        chk("b2b_first_ack", 32'(ack1), 32'd3);
        chk("b2b_second_ack", 32'(ack2), 32'd7);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            cpu_en    = ($urandom_range(0, 1) == 1);
            cpu_we    = 4'($urandom_range(0, 15));
            cpu_addr  = {23'd0, 7'($urandom_range(0, 69)), 2'($urandom_range(0, 3))};
            cpu_wdata = $urandom;
            host_req  = ($urandom_range(0, 3) == 0);
            host_we   = ($urandom_range(0, 1) == 1);
            host_addr = {23'd0, 7'($urandom_range(0, 79)), 2'($urandom_range(0, 3))};
            host_wdata = $urandom;
            tick();
        end
        cpu_en = 1'b0;  host_req = 1'b0;
        repeat (MAX_WAIT + 4) tick();

        bad_words = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        chk("final_memory_words_differing", 32'(bad_words), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
